// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers for the pipelined mux tree: select width, tree depth
// and padded leaf count, all derived from the number of inputs.
package mux_tree_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Select width and tree depth are the same quantity: max(1, clog2(n)).
    function automatic int sel_width(input int n);
        int c;
        c = clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int tree_levels(input int n);
        return sel_width(n);
    endfunction

    // Leaves are padded up to a full binary tree.
    function automatic int pad_leaves(input int n);
        return 1 << tree_levels(n);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One tree level: 2:1 muxes over adjacent node pairs steered by select bit 0,
// followed by a valid/ready pipeline register carrying nodes, select and error.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_NODES  = 2,
    parameter int SEL_IN_W = 1,
    parameter int N_OUT    = N_NODES / 2,
    parameter int SEL_O_W  = (SEL_IN_W > 1) ? SEL_IN_W - 1 : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [N_NODES*WIDTH-1:0] in_nodes_i,
    input  logic [SEL_IN_W-1:0]      in_sel_i,
    input  logic                     in_err_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [N_OUT*WIDTH-1:0]   out_nodes_o,
    output logic [SEL_O_W-1:0]       out_sel_o,
    output logic                     out_err_o
);

    logic                   valid_q;
    logic [N_OUT*WIDTH-1:0] nodes_q, nodes_d;
    logic [SEL_O_W-1:0]     sel_q, sel_d;
    logic                   err_q;
    logic                   advance;

    // An empty register always accepts, so bubbles collapse even under stall.
    assign advance    = !valid_q || out_ready_i;
    assign in_ready_o = advance;

    always_comb begin
        nodes_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            nodes_d[j*WIDTH +: WIDTH] = in_sel_i[0] ? in_nodes_i[(2*j+1)*WIDTH +: WIDTH]
                                                    : in_nodes_i[(2*j)*WIDTH +: WIDTH];
        end
    end

    generate
        if (SEL_IN_W > 1) begin : g_sel_rest
            assign sel_d = in_sel_i[SEL_IN_W-1:1];
        end else begin : g_sel_none
            assign sel_d = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            nodes_q <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else if (advance) begin
            valid_q <= in_valid_i;
            // Payload only loads with a real beat; idle input is never captured.
            if (in_valid_i) begin
                nodes_q <= nodes_d;
                sel_q   <= sel_d;
                err_q   <= in_err_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_nodes_o = nodes_q;
    assign out_sel_o   = sel_q;
    assign out_err_o   = err_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// N-input selector as a registered binary mux tree, one pipeline stage per level.
// Optional out-of-range select flagging: PIPELINED_MUX_TREE_SEL_CHECK_EN.
module pipelined_mux_tree
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 5,
    parameter int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [N_IN*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]      in_sel_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      out_data_o,
    output logic                  out_err_o
);

    localparam int LEVELS = tree_levels(N_IN);
    localparam int PAD    = pad_leaves(N_IN);

    logic [PAD*WIDTH-1:0] leaves;
    logic                 sel_err;

    generate
        if (PAD > N_IN) begin : g_pad
            assign leaves = {{((PAD - N_IN) * WIDTH){1'b0}}, in_data_i};
        end else begin : g_nopad
            assign leaves = in_data_i;
        end
    endgenerate

`ifdef PIPELINED_MUX_TREE_SEL_CHECK_EN
    // Extra bit so N_IN == 2**SEL_W compares correctly.
    assign sel_err = ({1'b0, in_sel_i} >= (SEL_W + 1)'(N_IN));
`else
    assign sel_err = 1'b0;
`endif

    generate
        for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
            localparam int NI = PAD >> k;
            localparam int NO = NI / 2;
            localparam int SI = LEVELS - k;
            localparam int SO = (SI > 1) ? SI - 1 : 1;

            logic [NI*WIDTH-1:0] nodes_in;
            logic [SI-1:0]       sel_in;
            logic                valid_in;
            logic                err_in;
            logic                rdy_in;
            logic                rdy_out;
            logic [NO*WIDTH-1:0] nodes_out;
            logic [SO-1:0]       sel_out;
            logic                valid_out;
            logic                err_out;

            if (k == 0) begin : g_head
                assign nodes_in = leaves;
                assign sel_in   = in_sel_i;
                assign valid_in = in_valid_i;
                assign err_in   = sel_err;
            end else begin : g_link
                assign nodes_in = g_lvl[k-1].nodes_out;
                assign sel_in   = g_lvl[k-1].sel_out;
                assign valid_in = g_lvl[k-1].valid_out;
                assign err_in   = g_lvl[k-1].err_out;
            end

            // Ready ripples back combinationally from the consumer.
            if (k == LEVELS - 1) begin : g_tail
                assign rdy_out = out_ready_i;
            end else begin : g_mid
                assign rdy_out = g_lvl[k+1].rdy_in;
            end

            mux_tree_stage #(
                .WIDTH   (WIDTH),
                .N_NODES (NI),
                .SEL_IN_W(SI)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .in_valid_i (valid_in),
                .in_ready_o (rdy_in),
                .in_nodes_i (nodes_in),
                .in_sel_i   (sel_in),
                .in_err_i   (err_in),
                .out_valid_o(valid_out),
                .out_ready_i(rdy_out),
                .out_nodes_o(nodes_out),
                .out_sel_o  (sel_out),
                .out_err_o  (err_out)
            );
        end
    endgenerate

    assign in_ready_o  = g_lvl[0].rdy_in;
    assign out_valid_o = g_lvl[LEVELS-1].valid_out;
    assign out_data_o  = g_lvl[LEVELS-1].nodes_out;
    assign out_err_o   = g_lvl[LEVELS-1].err_out;

endmodule

// File: doc/pipelined_mux_tree.md
# pipelined_mux_tree

Parametrised, pipelined N-input selector built as a binary 2:1 mux tree, with a register after every tree level and a valid/ready handshake on both sides. It replaces the hand-nested combinational ternary selectors with a block that works for any width and input count, sustains one selection per cycle, and tolerates downstream backpressure. It sits on datapath selection points where a deep combinational mux would limit timing.

## Interface
- `WIDTH`, 8: data bits per input.
- `N_IN`, 5: number of inputs, ≥1.
- `SEL_W`, derived as max(1, clog2(N_IN)): select width.
- `LEVELS`, derived as max(1, clog2(N_IN)): tree levels, equal to the number of pipeline stages.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: block accepts the beat this cycle.
- `in_data_i` in N_IN*WIDTH: input k occupies bits [k*WIDTH +: WIDTH].
- `in_sel_i` in SEL_W: index of the input to forward.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `out_data_o` out WIDTH: selected input.
- `out_err_o` out 1: select was out of range. Qualified by `out_valid_o`.

## Operation
- Result: `out_data_o` = input[in_sel_i], captured at the accept cycle.
- Padding: leaves are padded to 2^LEVELS. Padding leaves hold 0.
- Level k (k = 0 … LEVELS-1):
  - uses `sel[k]` (LSB at the leaf level) to choose between node pairs;
  - registers its ceil(2^LEVELS / 2^(k+1)) nodes, the remaining select bits, the error flag and a valid bit.
- Stage s advances when it is empty or stage s+1 advances. The last stage advances on `out_ready_i`.
- `in_ready_o` = stage 0 advances. This is a combinational ready chain, which gives bubble collapse: an empty stage accepts even while later stages are stalled.
- While a stage holds, its data, select and error bits are stable.
- Transfer occurs on valid && ready. Data presented without valid is ignored and is not registered.
- Reset (`rst_n`=0 at a rising edge):
  - all stage valids, data and error bits clear to 0;
  - `out_valid_o`=0, `out_data_o`=0, `out_err_o`=0;
  - in-flight beats are dropped, including a reset asserted mid-stream.
- Simultaneous input accept and output drain in the same cycle is legal. Occupancy is unchanged and nothing is lost.

## Timing
- Latency is LEVELS cycles from accept to `out_valid_o`, with `out_ready_i` held high. The default configuration is 3 cycles.
- Throughput is 1 beat per cycle under no backpressure.
- Capacity is LEVELS beats. When all stages are full and `out_ready_i`=0, `in_ready_o`=0 in the same cycle.
- The first accept after reset deassertion is allowed in the first cycle with `rst_n`=1.
- `out_valid_o` never drops while `out_ready_i`=0.

## Configuration
- `PIPELINED_MUX_TREE_SEL_CHECK_EN`:
  - Defined: `in_sel_i` ≥ N_IN sets the error bit at stage 0. The bit travels with the beat; the result is `out_data_o`=0 with `out_err_o`=1.
  - Undefined: no check. An out-of-range select resolves to a padding leaf, giving `out_data_o`=0, and `out_err_o` is tied to 0.
  - Port list is identical in both builds.

## Structure
- Shared package `mux_tree_pkg`:
  - `clog2` function;
  - `SEL_W` / `LEVELS` derivation function, max(1, clog2(n));
  - padded-leaf-count helper.
- Sub-module `mux_tree_stage`: one level. It holds the 2:1 muxes over paired nodes, the stage register, the valid and error bits, and the local advance logic. It is parametrised by node count and remaining select width.
- Top generates LEVELS instances and pads leaves.

## Test plan
- **Selection.** Defaults; inputs 0x11, 0x22, 0x33, 0x44, 0x55; `out_ready_i`=1; sel 0, 1, 2, 3, 4 back-to-back → outputs 11, 22, 33, 44, 55 on consecutive cycles, the first 3 cycles after its accept, `out_err_o`=0.
- **Out-of-range select.** sel=7 and sel=5:
  - macro defined → `out_data_o`=00 with `out_err_o`=1;
  - macro undefined → 00 with `out_err_o`=0.
- **Backpressure.** `out_ready_i`=0, offer 4 beats (sel 0, 1, 2, 3):
  - 3 are accepted, then `in_ready_o`=0;
  - `out_data_o` holds 11;
  - releasing ready drains 11, 22, 33, then 44 enters.
- **Bubble collapse.** One beat stalled at the output, stages 0–1 empty → `in_ready_o`=1 and the next two beats fill the earlier stages.
- **Reset mid-stream.** Pulse `rst_n` low 1 cycle with 3 beats in flight → next cycle `out_valid_o`=0 and data 0; no stale beat ever emerges.
- **Corner configurations.**
  - N_IN=1: latency 1, sel=0 passes.
  - N_IN=8, WIDTH=16: sel 0–7 each return their own input after 3 cycles; no errors.
